ctrl_pipe_hazard: RTL and testbench

//  Consumer end of the ID-stage decoded control bundle. Carries control bits and rd through the
//  ID/EX, EX/MEM and MEM/WB registers of the 5-stage RV32I pipeline. Detects load-use and ecall

---
 rtl/ctrl_pipe_hazard.sv | 105 ++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_hazard
// Brief    : ID/EX, EX/MEM and MEM/WB control/rd registers with load-use and
//            ecall hazard stalls plus halting-ecall drain for an RV32I pipe.
// Revision : 1.0
// ============================================================================
module ctrl_pipe_hazard #(
  parameter int RD_W      = 5,
  parameter int CTRL_W    = 7,
  parameter int ECALL_REG = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [RD_W-1:0]   id_rs1,
  input  logic [RD_W-1:0]   id_rs2,
  input  logic [RD_W-1:0]   id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_x17_is_10,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RD_W-1:0]   ex_rd,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [RD_W-1:0]   mem_rd,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RD_W-1:0]   wb_rd,
  output logic              is_halted
);

  localparam int C_MEM_READ     = 0;
  localparam int C_WRITE_ENABLE = 4;
  localparam int C_IS_ECALL     = 6;
  localparam logic [RD_W-1:0] C_ECALL_RD = RD_W'(ECALL_REG);

  logic [CTRL_W-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [RD_W-1:0]   r_ex_rd, r_mem_rd, r_wb_rd;
  logic              r_ex_halt, r_mem_halt, r_wb_halt;
  logic              r_drain, r_halted;

  logic w_load_use, w_ecall_haz, w_stall, w_bubble, w_halt_accept;

  always_comb begin
    w_load_use = r_ex_ctrl[C_MEM_READ] && (r_ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == r_ex_rd)));
    w_ecall_haz = id_ctrl[C_IS_ECALL] &&
                  ((r_ex_ctrl[C_WRITE_ENABLE] && (r_ex_rd == C_ECALL_RD)) ||
                   (r_mem_ctrl[C_MEM_READ] && (r_mem_rd == C_ECALL_RD)));
    w_stall       = w_load_use || w_ecall_haz;
    w_bubble      = w_stall || r_drain;
    w_halt_accept = id_ctrl[C_IS_ECALL] && id_x17_is_10 && !w_bubble;
  end

  // Drain is raised on the same edge the halting ecall enters EX and holds
  // until reset, so nothing younger than the ecall is ever accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_ctrl  <= '0;
      r_ex_rd    <= '0;
      r_ex_halt  <= 1'b0;
      r_mem_ctrl <= '0;
      r_mem_rd   <= '0;
      r_mem_halt <= 1'b0;
      r_wb_ctrl  <= '0;
      r_wb_rd    <= '0;
      r_wb_halt  <= 1'b0;
      r_drain    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_bubble) begin
        r_ex_ctrl <= '0;
        r_ex_rd   <= '0;
        r_ex_halt <= 1'b0;
      end else begin
        r_ex_ctrl <= id_ctrl;
        r_ex_rd   <= id_rd;
        r_ex_halt <= w_halt_accept;
      end
      r_mem_ctrl <= r_ex_ctrl;
      r_mem_rd   <= r_ex_rd;
      r_mem_halt <= r_ex_halt;
      r_wb_ctrl  <= r_mem_ctrl;
      r_wb_rd    <= r_mem_rd;
      r_wb_halt  <= r_mem_halt;
      r_drain    <= r_drain | w_halt_accept;
      r_halted   <= r_halted | r_wb_halt;
    end
  end

  assign pc_write   = !w_bubble;
  assign ifid_write = !w_bubble;
  assign ex_ctrl    = r_ex_ctrl;
  assign ex_rd      = r_ex_rd;
  assign mem_ctrl   = r_mem_ctrl;
  assign mem_rd     = r_mem_rd;
  assign wb_ctrl    = r_wb_ctrl;
  assign wb_rd      = r_wb_rd;
  // Halt is visible in the very cycle the ecall sits in MEM/WB, then sticky.
  assign is_halted  = r_wb_halt | r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_hazard
// Brief    : Directed vector table plus hand sequences for ctrl_pipe_hazard.
// Revision : 1.0
// ============================================================================
module tb_ctrl_pipe_hazard;

  localparam logic [6:0] C_NOP   = 7'h00;
  localparam logic [6:0] C_LW    = 7'h1B; // write_enable|alu_src|mem_to_reg|mem_read
  localparam logic [6:0] C_ADD   = 7'h10;
  localparam logic [6:0] C_ADDI  = 7'h18;
  localparam logic [6:0] C_ECALL = 7'h40;
  localparam int         C_NVEC  = 17;

  logic       clk, reset;
  logic [6:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_x17_is_10;
  logic       pc_write, ifid_write, is_halted;
  logic [6:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, x17;
    logic       e_pc;
    logic [6:0] e_ex;
    logic [4:0] e_exrd;
    logic [6:0] e_mem, e_wb;
    logic       e_halt;
  } vec_t;

  vec_t vec [C_NVEC];

  ctrl_pipe_hazard dut (
    .clk(clk), .reset(reset),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_x17_is_10(id_x17_is_10),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .is_halted(is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic u1, input logic u2, input logic x);
    id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_x17_is_10 = x;
  endtask

  initial begin
    //         ctrl     rs1  rs2  rd  u1 u2 x17 | pc ex       exrd mem      wb       halt
    vec[0]  = '{C_LW,    1,   0,   5, 1, 0, 0,    1, C_LW,    5,  C_NOP,   C_NOP,   0}; // lw x5
    vec[1]  = '{C_ADD,   5,   0,   6, 1, 0, 0,    0, C_NOP,   0,  C_LW,    C_NOP,   0}; // load-use stall
    vec[2]  = '{C_ADD,   5,   0,   6, 1, 0, 0,    1, C_ADD,   6,  C_NOP,   C_LW,    0}; // add enters EX
    vec[3]  = '{C_LW,    1,   0,   0, 1, 0, 0,    1, C_LW,    0,  C_ADD,   C_NOP,   0}; // lw x0
    vec[4]  = '{C_ADD,   0,   0,   7, 1, 0, 0,    1, C_ADD,   7,  C_LW,    C_ADD,   0}; // rd==0 no stall
    vec[5]  = '{C_ADDI,  1,   0,  17, 1, 0, 0,    1, C_ADDI, 17,  C_ADD,   C_LW,    0}; // addi x17
    vec[6]  = '{C_ECALL, 0,   0,   0, 0, 0, 0,    0, C_NOP,   0,  C_ADDI,  C_ADD,   0}; // ecall hazard EX
    vec[7]  = '{C_ECALL, 0,   0,   0, 0, 0, 0,    1, C_ECALL, 0,  C_NOP,   C_ADDI,  0}; // non-halting ecall
    vec[8]  = '{C_LW,    2,   0,  17, 1, 0, 0,    1, C_LW,   17,  C_ECALL, C_NOP,   0}; // lw x17
    vec[9]  = '{C_ADD,   3,   4,   8, 1, 1, 0,    1, C_ADD,   8,  C_LW,    C_ECALL, 0}; // ecall NOP in WB
    vec[10] = '{C_ECALL, 0,   0,   0, 0, 0, 0,    0, C_NOP,   0,  C_ADD,   C_LW,    0}; // ecall hazard MEM
    vec[11] = '{C_LW,    2,   0,  17, 1, 0, 0,    1, C_LW,   17,  C_NOP,   C_ADD,   0};
    vec[12] = '{C_ADDI,  1,   0,  17, 0, 0, 0,    1, C_ADDI, 17,  C_LW,    C_NOP,   0};
    vec[13] = '{C_ECALL, 0,   0,   0, 0, 0, 1,    0, C_NOP,   0,  C_ADDI,  C_LW,    0}; // both hazards
    vec[14] = '{C_ECALL, 0,   0,   0, 0, 0, 1,    1, C_ECALL, 0,  C_NOP,   C_ADDI,  0}; // halt accepted
    vec[15] = '{C_ADD,   1,   0,   9, 1, 0, 0,    0, C_NOP,   0,  C_ECALL, C_NOP,   0}; // draining
    vec[16] = '{C_ADD,   1,   0,   9, 1, 0, 0,    0, C_NOP,   0,  C_NOP,   C_ECALL, 1}; // halted

    reset = 1'b0;
    drive(C_NOP, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_pc_write", {31'd0, pc_write}, 32'd1);
    check("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
    check("rst_ex_ctrl", {25'd0, ex_ctrl}, 32'd0);
    check("rst_is_halted", {31'd0, is_halted}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < C_NVEC; i++) begin
      @(negedge clk);
      drive(vec[i].ctrl, vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].u1, vec[i].u2, vec[i].x17);
      #1;
      check($sformatf("v%0d_pc_write", i), {31'd0, pc_write}, {31'd0, vec[i].e_pc});
      check($sformatf("v%0d_ifid_write", i), {31'd0, ifid_write}, {31'd0, vec[i].e_pc});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ex_ctrl", i), {25'd0, ex_ctrl}, {25'd0, vec[i].e_ex});
      check($sformatf("v%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, vec[i].e_exrd});
      check($sformatf("v%0d_mem_ctrl", i), {25'd0, mem_ctrl}, {25'd0, vec[i].e_mem});
      check($sformatf("v%0d_wb_ctrl", i), {25'd0, wb_ctrl}, {25'd0, vec[i].e_wb});
      check($sformatf("v%0d_is_halted", i), {31'd0, is_halted}, {31'd0, vec[i].e_halt});
    end

    // Halt is sticky and drain holds off new work for many cycles.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(C_LW, 1, 0, 3, 1, 0, 0);
      #1;
      check($sformatf("sticky%0d_halted", i), {31'd0, is_halted}, 32'd1);
      check($sformatf("sticky%0d_pc_write", i), {31'd0, pc_write}, 32'd0);
      check($sformatf("sticky%0d_ex_ctrl", i), {25'd0, ex_ctrl}, 32'd0);
    end

    // Asynchronous reset clears a halted pipe without a clock edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_halted", {31'd0, is_halted}, 32'd0);
    check("async_rst_pc_write", {31'd0, pc_write}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-stream with loads in EX and MEM.
    drive(C_LW, 1, 0, 4, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(C_LW, 1, 0, 5, 1, 0, 0);
    @(posedge clk);
    #1;
    check("mid_pre_ex_ctrl", {25'd0, ex_ctrl}, {25'd0, C_LW});
    check("mid_pre_mem_ctrl", {25'd0, mem_ctrl}, {25'd0, C_LW});
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ex_ctrl", {25'd0, ex_ctrl}, 32'd0);
    check("mid_rst_mem_ctrl", {25'd0, mem_ctrl}, 32'd0);
    check("mid_rst_wb_ctrl", {25'd0, wb_ctrl}, 32'd0);
    check("mid_rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    check("mid_rst_pc_write", {31'd0, pc_write}, 32'd1);
    check("mid_rst_halted", {31'd0, is_halted}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
